mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the MIPS core. It sequences the shared datapath one instruction at a time through FETCH, DECODE, EXEC, MEM and WB states. It reads the IR opcode and function fields and the ALU zero flag, and drives every write enable and mux select for the PC, IR, GRF, ALU, EXT and DM. It replaces the single-cycle combinational controller and is the only block permitted to assert PC/IR/GRF/DM writes.

## Interface
- Parameters: none.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- op  in  6  IR[31:26], stable from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU equality flag, valid in EXEC
- mem_ready  in  1  DM completion (only with MC_MEM_WAIT_EN)
- pc_we  out  1  PC write
- npc_sel  out  2  0 PC+4, 1 branch (PC+4+sext(imm)<<2), 2 j/jal target, 3 rs (jr)
- ir_we  out  1  IR write
- reg_we  out  1  GRF write
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- wd_sel  out  2  0 ALU result, 1 DM read data, 2 current PC (already PC+4)
- alu_src  out  1  0 rt data, 1 EXT output
- alu_op  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16)
- ext_op  out  1  0 zero-extend, 1 sign-extend
- dm_we  out  1  DM write
- dm_re  out  1  DM read
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- instr_done  out  1  one-cycle pulse in an instruction's last cycle
- illegal  out  1  one-cycle pulse in DECODE on an unsupported encoding

## Operation
- Supported encodings:
  - R-type (op 000000): addu func 100001, subu 100011, jr 001000, nop func 000000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Any other encoding, including other R-type funcs, is illegal.
- FETCH: ir_we=1, pc_we=1, npc_sel=0 -> DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=2, instr_done -> FETCH.
  - jal: as j, plus reg_we=1, reg_dst=2, wd_sel=2.
  - jr: pc_we=1, npc_sel=3, instr_done -> FETCH.
  - nop: instr_done -> FETCH.
  - illegal: illegal=1, instr_done, no writes -> FETCH.
  - All others -> EXEC.
- EXEC:
  - addu/subu: alu_src=0, alu_op ADD/SUB -> WB.
  - ori: alu_src=1, ext_op=0, alu_op=OR -> WB.
  - lui: alu_src=1, alu_op=LUI -> WB.
  - lw/sw: alu_src=1, ext_op=1, alu_op=ADD -> MEM.
  - beq: alu_op=SUB, pc_we=zero, npc_sel=1, instr_done -> FETCH.
- MEM: ADD address path is held.
  - sw: dm_we=1, instr_done -> FETCH.
  - lw: dm_re=1 -> WB.
- WB: reg_we=1, wd_sel=1 for lw, otherwise 0. reg_dst=1 for R-type, otherwise 0. instr_done -> FETCH.
- Select outputs are don't-care when their enable is 0. They must still be driven, never X: default 0.
- State 5-7 (unreachable): outputs all 0, next state FETCH.

## Timing
- Control outputs are a combinational function of state, op, func and zero (Moore plus decode). State is registered.
- Cycles per instruction:
  - 2: j, jal, jr, nop, illegal
  - 3: beq
  - 4: addu, subu, ori, lui, sw
  - 5: lw
- Reset:
  - While reset=1, every enable (pc_we, ir_we, reg_we, dm_we, dm_re), instr_done and illegal is forced to 0.
  - The state register loads FETCH on the first clk edge with reset=1.
- Reset mid-instruction abandons it: no partial write occurs after the reset edge, and FETCH follows.
- beq not taken: the PC already holds PC+4 from FETCH, so no PC write occurs.

## Configuration
- MC_MEM_WAIT_EN defined:
  - In MEM the controller holds state and keeps dm_we/dm_re asserted until mem_ready=1.
  - sw completes and lw advances to WB in the mem_ready=1 cycle.
  - mem_ready is ignored in every other state.
- Undefined: the mem_ready port is absent and MEM always lasts exactly one cycle.

## Test plan
- Reset held 3 cycles, then released with IR=addu $3,$1,$2 (0x00221821) -> state 0,1,2,4,0; reg_we=1, reg_dst=1 only in WB; instr_done in cycle 4.
- lw (0x8C220004) -> 5 cycles; dm_re=1 in MEM; reg_we=1, wd_sel=1 in WB; with MC_MEM_WAIT_EN and mem_ready low for 2 cycles -> 7 cycles, dm_re held throughout.
- beq (0x10220003) with zero=1 -> pc_we=1, npc_sel=1 in EXEC; with zero=0 -> pc_we=0; both take 3 cycles.
- jal (0x0C000C10) -> DECODE asserts pc_we, npc_sel=2, reg_we, reg_dst=2, wd_sel=2; back to FETCH after 2 cycles.
- Illegal 0xFC000000 -> illegal pulse in DECODE, no write enables, 2 cycles.
- Reset asserted during sw MEM -> dm_we=0 that cycle, state FETCH next.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the MIPS datapath.
// Define MC_MEM_WAIT_EN to stall MEM until mem_ready; otherwise MEM is a single cycle.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_we,
    output logic [1:0] npc_sel,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       dm_we,
    output logic       dm_re,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;
    localparam logic [OP_W-1:0] FN_NOP   = 6'b000000;

    localparam logic [SEL_W-1:0] NPC_PC4  = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BR   = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JUMP = 2'd2;
    localparam logic [SEL_W-1:0] NPC_RS   = 2'd3;

    localparam logic [SEL_W-1:0] DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] DST_RA = 2'd2;

    localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WD_DM  = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC  = 2'd2;

    localparam logic [SEL_W-1:0] ALU_ADD = 2'd0;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'd1;
    localparam logic [SEL_W-1:0] ALU_OR  = 2'd2;
    localparam logic [SEL_W-1:0] ALU_LUI = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, legal;
    logic mem_go;

    logic             pc_we_c, ir_we_c, reg_we_c, dm_we_c, dm_re_c, done_c, illegal_c;
    logic [SEL_W-1:0] npc_sel_c, reg_dst_c, wd_sel_c, alu_op_c, alu_op_x;
    logic             alu_src_c, ext_op_c, alu_src_x, ext_op_x;

    // Instruction classification from the IR fields
    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (func == FN_ADDU);
    assign is_subu  = is_rtype && (func == FN_SUBU);
    assign is_jr    = is_rtype && (func == FN_JR);
    assign is_nop   = is_rtype && (func == FN_NOP);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign legal    = is_addu || is_subu || is_jr || is_nop || is_ori || is_lui
                   || is_lw || is_sw || is_beq || is_j || is_jal;

`ifdef MC_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    // ALU/EXT setting for the current instruction, applied from EXEC through WB
    always_comb begin
        alu_src_x = 1'b0;
        alu_op_x  = ALU_ADD;
        ext_op_x  = 1'b0;
        if (is_subu || is_beq) begin
            alu_op_x = ALU_SUB;
        end else if (is_ori) begin
            alu_src_x = 1'b1;
            alu_op_x  = ALU_OR;
        end else if (is_lui) begin
            alu_src_x = 1'b1;
            alu_op_x  = ALU_LUI;
        end else if (is_lw || is_sw) begin
            alu_src_x = 1'b1;
            ext_op_x  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we_c   = 1'b0;
        npc_sel_c = NPC_PC4;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        reg_dst_c = DST_RT;
        wd_sel_c  = WD_ALU;
        alu_src_c = 1'b0;
        alu_op_c  = ALU_ADD;
        ext_op_c  = 1'b0;
        dm_we_c   = 1'b0;
        dm_re_c   = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we_c   = 1'b1;
                pc_we_c   = 1'b1;
                npc_sel_c = NPC_PC4;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
                if (!legal) begin
                    illegal_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_we_c   = 1'b1;
                    npc_sel_c = NPC_JUMP;
                    done_c    = 1'b1;
                    state_d   = S_FETCH;
                    if (is_jal) begin
                        reg_we_c  = 1'b1;
                        reg_dst_c = DST_RA;
                        wd_sel_c  = WD_PC;
                    end
                end else if (is_jr) begin
                    pc_we_c   = 1'b1;
                    npc_sel_c = NPC_RS;
                    done_c    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_nop) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                ext_op_c  = ext_op_x;
                if (is_beq) begin
                    pc_we_c   = zero;
                    npc_sel_c = NPC_BR;
                    done_c    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                ext_op_c  = ext_op_x;
                if (is_sw) begin
                    dm_we_c = 1'b1;
                    if (mem_go) begin
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (is_lw) begin
                    dm_re_c = 1'b1;
                    if (mem_go) begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                alu_src_c = alu_src_x;
                alu_op_c  = alu_op_x;
                ext_op_c  = ext_op_x;
                reg_we_c  = 1'b1;
                wd_sel_c  = is_lw ? WD_DM : WD_ALU;
                reg_dst_c = is_rtype ? DST_RD : DST_RT;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset suppresses every write and pulse so an abandoned instruction leaves no trace
    assign pc_we      = pc_we_c   & ~reset;
    assign ir_we      = ir_we_c   & ~reset;
    assign reg_we     = reg_we_c  & ~reset;
    assign dm_we      = dm_we_c   & ~reset;
    assign dm_re      = dm_re_c   & ~reset;
    assign instr_done = done_c    & ~reset;
    assign illegal    = illegal_c & ~reset;
    assign npc_sel    = npc_sel_c;
    assign reg_dst    = reg_dst_c;
    assign wd_sel     = wd_sel_c;
    assign alu_src    = alu_src_c;
    assign alu_op     = alu_op_c;
    assign ext_op     = ext_op_c;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl; per-cycle expectations queued by the driver,
// popped and compared by a negedge monitor. Covers MC_MEM_WAIT_EN when defined.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic [1:0] npc_sel;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       dm_we;
        logic       dm_re;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string name;
        ctl_t  exp;
        ctl_t  mask;
    } chk_t;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                      K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_e;

    logic       clk;
    logic       reset;
    logic [5:0] op_r, fn_r;
    logic       zero_r;
`ifdef MC_MEM_WAIT_EN
    logic       rdy_r;
`endif
    logic       pc_we, ir_we, reg_we, alu_src, ext_op, dm_we, dm_re, instr_done, illegal;
    logic [1:0] npc_sel, reg_dst, wd_sel, alu_op;
    logic [2:0] state;

    chk_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op_r),
        .func       (fn_r),
        .zero       (zero_r),
`ifdef MC_MEM_WAIT_EN
        .mem_ready  (rdy_r),
`endif
        .pc_we      (pc_we),
        .npc_sel    (npc_sel),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .dm_we      (dm_we),
        .dm_re      (dm_re),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            chk_t c;
            ctl_t act;
            c   = sb_q.pop_front();
            act = {state, pc_we, npc_sel, ir_we, reg_we, reg_dst, wd_sel,
                   alu_src, alu_op, ext_op, dm_we, dm_re, instr_done, illegal};
            checks++;
            if ((act & c.mask) !== (c.exp & c.mask)) begin
                failures++;
                $display("FAIL %s: got %05h want %05h (care %05h)", c.name, act, c.exp, c.mask);
            end
        end
    end

    function automatic ctl_t st(logic [2:0] s);
        ctl_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    // Selects only matter while their enable is set; ALU fields only where named
    function automatic ctl_t mk_mask(ctl_t e, logic c_src, logic c_op, logic c_ext);
        ctl_t m;
        m = '0;
        m.state = '1; m.pc_we = 1'b1; m.ir_we = 1'b1; m.reg_we = 1'b1;
        m.dm_we = 1'b1; m.dm_re = 1'b1; m.instr_done = 1'b1; m.illegal = 1'b1;
        if (e.pc_we) m.npc_sel = '1;
        if (e.reg_we) begin
            m.reg_dst = '1;
            m.wd_sel  = '1;
        end
        if (c_src) m.alu_src = 1'b1;
        if (c_op)  m.alu_op  = '1;
        if (c_ext) m.ext_op  = 1'b1;
        return m;
    endfunction

    task automatic step(string nm, logic rst, ctl_t e, logic c_src, logic c_op, logic c_ext);
        chk_t c;
        reset  = rst;
        c.name = nm;
        c.exp  = e;
        c.mask = mk_mask(e, c_src, c_op, c_ext);
        sb_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and queue its hand-derived per-cycle control pattern
    task automatic run(string nm, logic [31:0] ir, logic z, kind_e k, int mem_wait, bit rst_in_mem);
        ctl_t e;
        op_r   = ir[31:26];
        fn_r   = ir[5:0];
        zero_r = z;
`ifdef MC_MEM_WAIT_EN
        rdy_r  = (mem_wait == 0);
`endif
        e = st(3'd0); e.ir_we = 1'b1; e.pc_we = 1'b1; e.npc_sel = 2'd0;
        step({nm, ".fetch"}, 1'b0, e, 1'b0, 1'b0, 1'b0);

        e = st(3'd1);
        case (k)
            K_J:   begin e.pc_we = 1'b1; e.npc_sel = 2'd2; e.instr_done = 1'b1; end
            K_JAL: begin
                e.pc_we = 1'b1; e.npc_sel = 2'd2; e.instr_done = 1'b1;
                e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
            end
            K_JR:  begin e.pc_we = 1'b1; e.npc_sel = 2'd3; e.instr_done = 1'b1; end
            K_NOP: e.instr_done = 1'b1;
            K_ILL: begin e.illegal = 1'b1; e.instr_done = 1'b1; end
            default: ;
        endcase
        step({nm, ".decode"}, 1'b0, e, 1'b0, 1'b0, 1'b0);
        if (e.instr_done) return;

        e = st(3'd2);
        case (k)
            K_ADDU: step({nm, ".exec"}, 1'b0, e, 1'b1, 1'b1, 1'b0);
            K_SUBU: begin e.alu_op = 2'd1; step({nm, ".exec"}, 1'b0, e, 1'b1, 1'b1, 1'b0); end
            K_ORI:  begin e.alu_src = 1'b1; e.alu_op = 2'd2; step({nm, ".exec"}, 1'b0, e, 1'b1, 1'b1, 1'b1); end
            K_LUI:  begin e.alu_src = 1'b1; e.alu_op = 2'd3; step({nm, ".exec"}, 1'b0, e, 1'b1, 1'b1, 1'b0); end
            K_BEQ:  begin
                e.alu_op = 2'd1; e.pc_we = z; e.npc_sel = 2'd1; e.instr_done = 1'b1;
                step({nm, ".exec"}, 1'b0, e, 1'b0, 1'b1, 1'b0);
                return;
            end
            default: begin e.alu_src = 1'b1; e.ext_op = 1'b1; step({nm, ".exec"}, 1'b0, e, 1'b1, 1'b1, 1'b1); end
        endcase

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mem_wait; i++) begin
`ifdef MC_MEM_WAIT_EN
                rdy_r = (i == mem_wait);
`endif
                if (rst_in_mem) begin
                    step({nm, ".mem_reset"}, 1'b1, st(3'd3), 1'b0, 1'b0, 1'b0);
                    return;
                end
                e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
                if (k == K_SW) begin
                    e.dm_we = 1'b1;
                    e.instr_done = (i == mem_wait);
                end else begin
                    e.dm_re = 1'b1;
                end
                step({nm, ".mem"}, 1'b0, e, 1'b1, 1'b1, 1'b1);
            end
            if (k == K_SW) return;
        end

        e = st(3'd4); e.reg_we = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
        step({nm, ".wb"}, 1'b0, e, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        op_r   = 6'd0;
        fn_r   = 6'd0;
        zero_r = 1'b0;
`ifdef MC_MEM_WAIT_EN
        rdy_r  = 1'b1;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, st(3'd0), 1'b0, 1'b0, 1'b0);

        run("addu",     32'h00221821, 1'b0, K_ADDU, 0, 0);
        run("subu",     32'h00221823, 1'b0, K_SUBU, 0, 0);
        run("ori",      32'h34220005, 1'b0, K_ORI,  0, 0);
        run("lui",      32'h3C01ABCD, 1'b0, K_LUI,  0, 0);
        run("lw",       32'h8C220004, 1'b0, K_LW,   0, 0);
        run("sw",       32'hAC220004, 1'b0, K_SW,   0, 0);
        run("beq_t",    32'h10220003, 1'b1, K_BEQ,  0, 0);
        run("beq_nt",   32'h10220003, 1'b0, K_BEQ,  0, 0);
        run("jal",      32'h0C000C10, 1'b0, K_JAL,  0, 0);
        run("j",        32'h08000C10, 1'b0, K_J,    0, 0);
        run("jr",       32'h03E00008, 1'b0, K_JR,   0, 0);
        run("nop",      32'h00000000, 1'b0, K_NOP,  0, 0);
        run("ill_op",   32'hFC000000, 1'b0, K_ILL,  0, 0);
        run("ill_func", 32'h00221820, 1'b0, K_ILL,  0, 0);
        run("sw_abort", 32'hAC220004, 1'b0, K_SW,   0, 1);
        run("addu_2",   32'h00221821, 1'b0, K_ADDU, 0, 0);
`ifdef MC_MEM_WAIT_EN
        run("lw_wait",  32'h8C220004, 1'b0, K_LW,   2, 0);
        run("sw_wait",  32'hAC220004, 1'b0, K_SW,   1, 0);
        run("ori_2",    32'h34220005, 1'b0, K_ORI,  0, 0);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
